// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
// State encoding 2'd3 is unused and recovers to IDLE.
package seq_divider_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam logic [DIVISOR_W-1:0] ERR_FILL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divide-by-zero, or a quotient that cannot fit in DIVISOR_W bits.
  function automatic logic div_error(input logic [DIVIDEND_W-1:0] p,
                                     input logic [DIVISOR_W-1:0]  m);
    return (m == '0) || (p[DIVIDEND_W-1:DIVISOR_W] >= m);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, then
// conditionally subtract the divisor.
import seq_divider_pkg::*;

module div_step (
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] M,
  output logic [DIVISOR_W:0]   rem_next,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] t;

  always_comb begin
    t        = {rem, bit_in};
    rem_next = t;
    q_bit    = 1'b0;
    if (t >= {1'b0, M}) begin
      rem_next = t - {1'b0, M};
      q_bit    = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential 8/4 restoring divider, one iteration per clock, with a
// start/busy/done handshake. Overflowing or zero divisors finish at once.
import seq_divider_pkg::*;

module seq_divider (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] P,
  input  logic [DIVISOR_W-1:0]  M,
  output logic [DIVISOR_W-1:0]  Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t               state, state_nxt;
  logic [1:0]           cnt;
  logic [DIVISOR_W-1:0] div_m;
  logic [DIVISOR_W-1:0] lo;
  logic [DIVISOR_W-1:0] rem;
  logic [DIVISOR_W:0]   rem_next;
  logic                 q_bit;
  logic                 accept;
  logic                 acc_err;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign acc_err = div_error(P, M);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  div_step u_step (
    .rem      (rem),
    .bit_in   (lo[DIVISOR_W-1]),
    .M        (div_m),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = acc_err ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     state_nxt = (cnt == 2'd0) ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      Q     <= '0;
      R     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 2'd3;
        if (acc_err) begin
          Q   <= ERR_FILL;
          R   <= ERR_FILL;
          err <= 1'b1;
        end else begin
          err <= 1'b0;
        end
      end else if (state == RUN) begin
        cnt <= cnt - 2'd1;
        Q   <= {Q[DIVISOR_W-2:0], q_bit};
        if (cnt == 2'd0) begin
          R <= rem_next[DIVISOR_W-1:0];
          // Top bit cannot be set once the overflow precheck passed.
          err <= rem_next[DIVISOR_W];
        end
      end
    end
  end

  // Datapath latches: only ever read while RUN, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_m <= M;
      lo    <= P[DIVISOR_W-1:0];
      rem   <= P[DIVIDEND_W-1:DIVISOR_W];
    end else if (state == RUN) begin
      rem <= rem_next[DIVISOR_W-1:0];
      lo  <= {lo[DIVISOR_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive bench for seq_divider with a result scoreboard.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] P;
  logic [3:0] M;
  logic [3:0] Q, R;
  logic       busy, done, err;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  seq_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .P     (P),
    .M     (M),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] p, input logic [3:0] m);
    exp_t e;
    if (m == 4'd0 || p[7:4] >= m) begin
      e.q = 4'hF; e.r = 4'hF; e.err = 1'b1;
    end else begin
      e.q = 4'(p / m); e.r = 4'(p % m); e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] p, input logic [3:0] m);
    P = p;
    M = m;
    start = 1'b1;
    sb.push_back(model(p, m));
    tick();
    start = 1'b0;
    P = 8'($urandom);
    M = 4'($urandom);
  endtask

  // Called in the cycle numbered lat0 after the accepting edge, with busy0
  // busy cycles already seen; waits for done and scores the result.
  task automatic collect(input string tag, input int lat0, input int busy0);
    int   lat;
    int   busy_n;
    exp_t e;
    lat = lat0;
    busy_n = busy0;
    while (!done && lat < 12) begin
      busy_n += int'(busy);
      tick();
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_done"}, 8'(done), 8'd1);
    check({tag, "_q"}, 8'(Q), 8'(e.q));
    check({tag, "_r"}, 8'(R), 8'(e.r));
    check({tag, "_err"}, 8'(err), 8'(e.err));
    check({tag, "_lat"}, 8'(lat), e.err ? 8'd1 : 8'd5);
    check({tag, "_busycyc"}, 8'(busy_n), e.err ? 8'd0 : 8'd4);
    check({tag, "_busy_at_done"}, 8'(busy), 8'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] p, input logic [3:0] m);
    issue(p, m);
    collect(tag, 1, 0);
  endtask

  initial begin
    int   bn;
    logic dseen;
    rst = 1'b1; start = 1'b0; P = '0; M = '0;
    tick(); tick();
    check("rst_q", 8'(Q), 8'd0);
    check("rst_r", 8'(R), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    // Reset beats a simultaneous start.
    start = 1'b1; P = 8'd143; M = 4'd11;
    tick();
    start = 1'b0;
    check("rst_vs_start_busy", 8'(busy), 8'd0);
    rst = 1'b0;
    tick();

    run_op("p143m11", 8'd143, 4'd11);
    tick();
    check("done_one_pulse", 8'(done), 8'd0);
    run_op("p200m15", 8'd200, 4'd15);
    run_op("p225m15", 8'd225, 4'd15);
    run_op("p0m7", 8'd0, 4'd7);
    run_op("ovf_p50m5", 8'h50, 4'd5);
    run_op("dz_p3cm0", 8'h3C, 4'd0);
    tick();

    // Start pulsed mid-RUN must be ignored.
    issue(8'd143, 4'd11);
    bn = int'(busy);
    tick();
    bn += int'(busy);
    P = 8'd50; M = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    collect("ign", 3, bn);

    // Start held through DONE launches the next operation immediately.
    P = 8'd200; M = 4'd15; start = 1'b1;
    sb.push_back(model(8'd200, 4'd15));
    tick();
    start = 1'b0;
    check("b2b_done_low", 8'(done), 8'd0);
    check("b2b_busy", 8'(busy), 8'd1);
    collect("b2b", 1, 0);
    tick();

    // Reset on the third RUN cycle aborts without a done pulse.
    P = 8'd143; M = 4'd11; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("abort_in_run", 8'(busy), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_q", 8'(Q), 8'd0);
    check("abort_r", 8'(R), 8'd0);
    check("abort_busy", 8'(busy), 8'd0);
    check("abort_done", 8'(done), 8'd0);
    check("abort_err", 8'(err), 8'd0);
    dseen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dseen |= done;
      tick();
    end
    check("abort_no_done", 8'(dseen), 8'd0);
    run_op("after_abort", 8'd143, 4'd11);

    // Exhaustive sweep, results checked against arithmetic division.
    for (int m = 0; m < 16; m++) begin
      for (int p = 0; p < 256; p++) begin
        run_op("sweep", 8'(p), 4'(m));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider that inverts the 4x4 array multiplier's operation: it takes an 8-bit product-width dividend and a 4-bit divisor, and returns a 4-bit quotient and 4-bit remainder. It sits beside the multiplier in the arithmetic datapath. Multiplier results can be round-tripped through it (P / M → Q, remainder 0). One restoring iteration per clock, with a start/busy/done handshake.

## Interface
- No parameters; widths fixed at 8-bit dividend, 4-bit divisor, quotient and remainder.
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only when ready
- P  input  8  dividend; captured on accepted start
- M  input  4  divisor; captured on accepted start
- Q  output  4  quotient; registered
- R  output  4  remainder; registered
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when Q/R/err are valid
- err  output  1  valid with done: divide-by-zero or quotient overflow

## Operation
- States:
  - IDLE: ready, busy=0.
  - RUN: 4 iterations, busy=1, 2-bit counter i=3..0.
  - DONE: 1 cycle, done=1.
- Accept condition:
  - start=1 in IDLE or DONE.
  - start in RUN is ignored; it is not queued.
- On accept:
  - Latch M.
  - Latch dividend low nibble P[3:0] into shift register.
  - Set 5-bit partial remainder rem = {1'b0, P[7:4]}.
- Error check on accept (combinational on inputs):
  - M==0 → err.
  - P[7:4] >= M → err (quotient would exceed 4 bits).
  - On err: skip RUN and go to DONE with err=1, Q=4'hF, R=4'hF.
- RUN iteration for each i, one per cycle:
  - t = {rem[3:0], P[i]} (5-bit).
  - If t >= {1'b0,M}: rem=t−M, Q[i]=1.
  - Else: rem=t, Q[i]=0.
- After i=0:
  - R=rem[3:0]; rem[4] is always 0 by the precondition.
  - err=0.
  - Go to DONE.
- DONE:
  - Next state RUN if start is accepted, else IDLE.
- Output holding:
  - Q, R, err hold their last values until the next accepted start.
  - They may change during RUN as internal shifting; the bench checks them only at done.
- Invariant when err=0: Q*M + R == P and R < M.

## Timing
- Reset values: state=IDLE, Q=0, R=0, busy=0, done=0, err=0, counter=0.
- Normal latency: start accepted at edge k → busy=1 after edges k+1..k+4 → done=1 for exactly the cycle after edge k+4 (5 cycles start-to-done), busy=0 in that cycle.
- Error latency: start at edge k → done=1, err=1 in the cycle after edge k (1 cycle); busy never asserts.
- Back-to-back: start held high during DONE → new operation accepted at that edge; done deasserts next cycle and busy rises. Throughput is one result per 5 cycles.
- Reset mid-operation: rst=1 at any edge forces IDLE and all reset values at that edge, aborting any RUN. No done pulse for the aborted operation. rst wins over start in the same cycle.
- Inputs P and M may change freely after the accepting edge; only the latched copies are used.

## Structure
- Shared header/package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Width constants: DIVIDEND_W=8, DIVISOR_W=4.
  - Error fill value 4'hF.
- One sub-module, `div_step`: combinational 5-bit shift/compare/subtract, with inputs rem[3:0], bit_in, M and outputs rem_next[4:0], q_bit.
  - Instantiated once and reused each RUN cycle.
- Top holds the FSM, counter, latches and output registers.

## Test plan
- P=143, M=11, start one cycle → done 5 cycles later, Q=13, R=0, err=0; busy high exactly 4 cycles.
- P=200, M=15 → Q=13, R=5, err=0. P=225, M=15 → Q=15, R=0 (maximum quotient). P=0, M=7 → Q=0, R=0.
- P=8'h50, M=5 (overflow) → done next cycle, err=1, Q=4'hF, R=4'hF, busy stays 0. P=8'h3C, M=0 → same err response.
- Start pulsed during RUN with different P/M → ignored; first result (P=143, M=11 → Q=13, R=0) delivered on schedule. Then start held high through DONE → second operation begins without an IDLE cycle.
- rst=1 on the third RUN cycle → next cycle all outputs at reset values, no done pulse. A fresh start after reset completes correctly.
- Exhaustive sweep of all P (0..255) × M (1..15) → err=1 exactly when P[7:4]>=M; otherwise Q*M+R==P and R<M.
